freq_calc: RTL and testbench

- Downstream consumer of the 64-bit measurement word {ref_clk_sum[63:32], sig_clk_sum[31:0]} produced once per gate period by the frequency-measure stage.
- Converts each count pair into a frequency in Hz: freq = floor(sig_sum * REF_FREQ_HZ / ref_sum).
- Uses a one-cycle multiply followed by a serial restoring divider, and presents a registered result with a one-cycle valid strobe to the register/AXI side.

---
 rtl/freq_calc_pkg.sv | 18 +
 rtl/seq_div.sv | 55 +++++
 rtl/freq_calc.sv | 155 +++++++++++++++
 tb/tb_freq_calc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/freq_calc_pkg.sv
// rtl/freq_calc_pkg.sv - shared types and constants for the frequency calculator
package freq_calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIV_ITER = 64;
    localparam int FLAG_DZ  = 0;
    localparam int FLAG_SAT = 1;
    localparam int FLAG_OVR = 2;

    localparam logic [31:0] DEF_REF_FREQ_HZ = 32'd100_000_000;

endpackage

// File: rtl/seq_div.sv
// rtl/seq_div.sv - 64/32 serial restoring divider, one quotient bit per cycle
module seq_div
    import freq_calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [63:0] quotient,
    output logic [31:0] remainder
);

    logic [63:0] quo;
    logic [31:0] rem;
    logic [31:0] divisor_q;
    logic [5:0]  cnt;
    logic        running;
    logic [32:0] trial;
    logic        take;

    // The partial remainder stays below the divisor, so the shifted trial fits in 33 bits.
    assign trial = {rem, quo[63]};
    assign take  = trial >= {1'b0, divisor_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo       <= '0;
            rem       <= '0;
            divisor_q <= '0;
            cnt       <= '0;
            running   <= 1'b0;
        end else if (start) begin
            quo       <= dividend;
            rem       <= '0;
            divisor_q <= divisor;
            cnt       <= 6'(DIV_ITER - 1);
            running   <= 1'b1;
        end else if (running) begin
            quo <= {quo[62:0], take};
            rem <= take ? 32'(trial - {1'b0, divisor_q}) : trial[31:0];
            if (cnt == 6'd0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - 6'd1;
            end
        end
    end

    assign done      = running && (cnt == 6'd0);
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/freq_calc.sv
// rtl/freq_calc.sv - converts ref/sig count pairs into a frequency in Hz
module freq_calc
    import freq_calc_pkg::*;
#(
    parameter logic [31:0] REF_FREQ_HZ = DEF_REF_FREQ_HZ,
    parameter int          QUO_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_en_i,
    input  logic [63:0]      in_data_i,
    output logic             out_en_o,
    output logic [QUO_W-1:0] out_freq_o,
    output logic [2:0]       out_flags_o,
    output logic             busy_o,
    input  logic             clr_ovr_i
);

    state_t state, state_next;

    logic        buf_valid;
    logic [63:0] buf_data;
    logic [31:0] op_ref, op_sig;
    logic        dz_q;
    logic        ovr;
    logic        flag_dz, flag_sat;
    logic [QUO_W-1:0] freq_q;
    logic        out_en_q;

    logic        latch_direct, latch_buf, div_start, div_done;
    logic        buf_write, ovr_set;
    logic [63:0] product;
    logic [63:0] quotient;
    logic [31:0] div_rem_unused;
    logic        quo_sat;

    assign product = 64'(op_sig) * 64'(REF_FREQ_HZ);
    assign quo_sat = (quotient >> QUO_W) != 64'd0;

    // Only IDLE starts conversions, so a buffer write and a buffer read never coincide.
    assign buf_write = in_en_i && (state != IDLE);
    assign ovr_set   = buf_write && buf_valid;

    always_comb begin
        state_next   = state;
        latch_direct = 1'b0;
        latch_buf    = 1'b0;
        div_start    = 1'b0;
        case (state)
            IDLE: begin
                if (in_en_i) begin
                    latch_direct = 1'b1;
                    state_next   = MUL;
                end else if (buf_valid) begin
                    latch_buf  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (op_ref == 32'd0) begin
                    state_next = DONE;
                end else begin
                    div_start  = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            op_ref    <= '0;
            op_sig    <= '0;
            dz_q      <= 1'b0;
            ovr       <= 1'b0;
            flag_dz   <= 1'b0;
            flag_sat  <= 1'b0;
            freq_q    <= '0;
            out_en_q  <= 1'b0;
        end else begin
            state    <= state_next;
            out_en_q <= (state == DONE);

            if (latch_direct) begin
                {op_ref, op_sig} <= in_data_i;
            end else if (latch_buf) begin
                {op_ref, op_sig} <= buf_data;
            end

            if (buf_write) begin
                buf_data  <= in_data_i;
                buf_valid <= 1'b1;
            end else if (latch_buf) begin
                buf_valid <= 1'b0;
            end

            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (clr_ovr_i) begin
                ovr <= 1'b0;
            end

            if (state == MUL) begin
                dz_q <= (op_ref == 32'd0);
            end

            if (state == DONE) begin
                if (dz_q) begin
                    freq_q   <= '1;
                    flag_dz  <= 1'b1;
                    flag_sat <= 1'b0;
                end else if (quo_sat) begin
                    freq_q   <= '1;
                    flag_dz  <= 1'b0;
                    flag_sat <= 1'b1;
                end else begin
                    freq_q   <= quotient[QUO_W-1:0];
                    flag_dz  <= 1'b0;
                    flag_sat <= 1'b0;
                end
            end
        end
    end

    seq_div u_seq_div (
        .clk       (clk_i),
        .rst       (rst_i),
        .start     (div_start),
        .dividend  (product),
        .divisor   (op_ref),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (div_rem_unused)
    );

    assign out_en_o              = out_en_q;
    assign out_freq_o            = freq_q;
    assign out_flags_o[FLAG_DZ]  = flag_dz;
    assign out_flags_o[FLAG_SAT] = flag_sat;
    assign out_flags_o[FLAG_OVR] = ovr;
    assign busy_o                = (state != IDLE);

endmodule

// File: tb/tb_freq_calc.sv
// tb/tb_freq_calc.sv - scoreboard bench for freq_calc
module tb_freq_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_en;
    logic [63:0] in_data;
    logic        clr_ovr;
    logic        out_en;
    logic [31:0] out_freq;
    logic [2:0]  out_flags;
    logic        busy;

    always #5 clk = ~clk;

    freq_calc dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_en_i     (in_en),
        .in_data_i   (in_data),
        .out_en_o    (out_en),
        .out_freq_o  (out_freq),
        .out_flags_o (out_flags),
        .busy_o      (busy),
        .clr_ovr_i   (clr_ovr)
    );

    typedef struct {
        logic [31:0] freq;
        logic [1:0]  flags;
        time         t;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    localparam time LAT_DIV = 665;
    localparam time LAT_DZ  = 25;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] s, output time t);
        in_data = {r, s};
        in_en   = 1'b1;
        @(posedge clk);
        t = $time;
        #1 in_en = 1'b0;
    endtask

    task automatic expect_res(input logic [31:0] f, input logic [1:0] fl, input time t);
        exp_t e;
        e.freq  = f;
        e.flags = fl;
        e.t     = t;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain_queue_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("idle_after_drain", {63'd0, busy}, 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_en", {63'd0, out_en}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("freq", {32'd0, out_freq}, {32'd0, e.freq});
                chk("flags", {62'd0, out_flags[1:0]}, {62'd0, e.flags});
                chk("latency", 64'($time), 64'(e.t));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t, ta, td;
        rst     = 1'b1;
        in_en   = 1'b0;
        in_data = '0;
        clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_en", {63'd0, out_en}, 64'd0);
        chk("rst_freq", {32'd0, out_freq}, 64'd0);
        chk("rst_flags", {61'd0, out_flags}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(32'd100_000, 32'd1_000, t);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        expect_res(32'd1_000_000, 2'b00, t + LAT_DIV);
        drain();

        send(32'd600_000_000, 32'd6, t);
        expect_res(32'd1, 2'b00, t + LAT_DIV);
        drain();
        send(32'd3, 32'd1, t);
        expect_res(32'd33_333_333, 2'b00, t + LAT_DIV);
        drain();

        send(32'd0, 32'd500, t);
        expect_res(32'hFFFF_FFFF, 2'b01, t + LAT_DZ);
        drain();
        send(32'd100_000, 32'd1_000, t);
        expect_res(32'd1_000_000, 2'b00, t + LAT_DIV);
        drain();

        send(32'd1, 32'hFFFF_FFFF, t);
        expect_res(32'hFFFF_FFFF, 2'b10, t + LAT_DIV);
        drain();
        send(32'd5, 32'd0, t);
        expect_res(32'd0, 2'b00, t + LAT_DIV);
        drain();

        // A computed, B overwritten by C, C starts one cycle after A completes
        send(32'd100_000, 32'd1_000, ta);
        expect_res(32'd1_000_000, 2'b00, ta + LAT_DIV);
        repeat (9) @(posedge clk);
        #1;
        send(32'd3, 32'd1, t);
        chk("ovr_after_b", {63'd0, out_flags[2]}, 64'd0);
        repeat (9) @(posedge clk);
        #1;
        send(32'd600_000_000, 32'd6, t);
        expect_res(32'd1, 2'b00, ta + 1335);
        chk("ovr_after_c", {63'd0, out_flags[2]}, 64'd1);
        drain();
        chk("ovr_sticky", {63'd0, out_flags[2]}, 64'd1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        chk("ovr_cleared", {63'd0, out_flags[2]}, 64'd0);

        // overwrite coincident with clear: set wins
        send(32'd100_000, 32'd1_000, td);
        expect_res(32'd1_000_000, 2'b00, td + LAT_DIV);
        repeat (4) @(posedge clk);
        #1;
        send(32'd0, 32'd500, t);
        repeat (4) @(posedge clk);
        #1;
        clr_ovr = 1'b1;
        send(32'd3, 32'd1, t);
        clr_ovr = 1'b0;
        expect_res(32'd33_333_333, 2'b00, td + 1335);
        chk("ovr_set_wins", {63'd0, out_flags[2]}, 64'd1);
        drain();
        clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        chk("ovr_cleared_again", {63'd0, out_flags[2]}, 64'd0);

        // reset mid-division: aborted sample must never produce out_en
        send(32'd100_000, 32'd1_000, t);
        repeat (31) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_en", {63'd0, out_en}, 64'd0);
        chk("midrst_freq", {32'd0, out_freq}, 64'd0);
        chk("midrst_flags", {61'd0, out_flags}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        send(32'd100_000, 32'd1_000, t);
        expect_res(32'd1_000_000, 2'b00, t + LAT_DIV);
        drain();
        chk("final_flags", {61'd0, out_flags}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
